// File: rtl/mips_dmem_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_dmem_ctrl_if
// Request/response bus between a load/store unit and the data memory controller.
//   master : the requester. It drives req_valid/req_we/req_addr/req_wdata/req_be
//            and receives req_ready plus the rsp_valid/rsp_rdata/rsp_err response.
//   slave  : the memory controller, with the opposite directions.
// ----------------------------------------------------------------------------
interface mips_dmem_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mips_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// mips_dmem_ctrl
// Word-addressed data memory with byte-enabled stores, a one-cycle response,
// out-of-range error reporting, a backdoor preload port and an optional
// post-reset clearing pass.
// Ports:
//   clk1      : sole clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/response bus (slave side)
//   load_en   : backdoor full-word write strobe; blocks requests while high
//   load_addr : backdoor word address (addresses >= DEPTH are dropped)
//   load_data : backdoor write data
//   busy      : high while the clearing pass runs
// ----------------------------------------------------------------------------
module mips_dmem_ctrl #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int DEPTH      = 1024,
    parameter bit INIT_CLEAR = 1'b1
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    mips_dmem_ctrl_if.slave      bus,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [DATA_W-1:0]    load_data,
    output logic                 busy
);
    localparam int NB = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_READY} state_t;
    localparam state_t RST_STATE = INIT_CLEAR ? ST_INIT : ST_READY;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic req_in_range;
    logic load_in_range;
    logic accept;

    assign req_in_range  = {1'b0, bus.req_addr} < DEPTH_L;
    assign load_in_range = {1'b0, load_addr} < DEPTH_L;

    // Backdoor loading takes the memory port, so requests stall while it is active.
    assign bus.req_ready = (state_q == ST_READY) && !load_en;
    assign accept        = bus.req_valid && bus.req_ready;
    assign busy          = (state_q == ST_INIT);

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rsp_valid_d = accept;
        rsp_err_d   = accept && !req_in_range;
        rsp_rdata_d = '0;

        if (state_q == ST_INIT) begin
            if (clr_cnt_q == LAST_IDX) begin
                state_d   = ST_READY;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
        end

        // A store accepted last cycle was already written at that edge, so this
        // read sees it (read-after-write returns the new data).
        if (accept && !bus.req_we && req_in_range) begin
            rsp_rdata_d = mem[bus.req_addr];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            clr_cnt_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // NOTE: the array has no reset; contents survive rst_n and only the clearing
    // pass zeroes them, which also keeps the array mappable onto RAM.
    always_ff @(posedge clk1) begin
        if (state_q == ST_INIT) begin
            mem[clr_cnt_q] <= '0;
        end else if (accept && bus.req_we && req_in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bus.req_be[b]) begin
                    mem[bus.req_addr][8*b +: 8] <= bus.req_wdata[8*b +: 8];
                end
            end
        end
        // Placed last so a backdoor write overrides the clear of the same word.
        if (load_en && load_in_range) begin
            mem[load_addr] <= load_data;
        end
    end
endmodule

// File: tb/tb_mips_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mips_dmem_ctrl
// Directed test of two controller instances sharing clock and reset:
//   dut_a : DEPTH=1024, INIT_CLEAR=1 (clearing pass, data path, backdoor)
//   dut_b : DEPTH=1000, INIT_CLEAR=0 (range errors, async reset of a response)
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or shortly after a rising edge.
// ----------------------------------------------------------------------------
module tb_mips_dmem_ctrl;
    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        a_load_en, b_load_en;
    logic [9:0]  a_load_addr, b_load_addr;
    logic [31:0] a_load_data, b_load_data;
    logic        a_busy, b_busy;

    int total = 0;
    int bad   = 0;
    int n_busy;
    int n_rdy;

    always #5 clk1 = ~clk1;

    mips_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(10)) a_if ();
    mips_dmem_ctrl_if #(.DATA_W(32), .ADDR_W(10)) b_if ();

    mips_dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .INIT_CLEAR(1'b1)) dut_a (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .bus       (a_if),
        .load_en   (a_load_en),
        .load_addr (a_load_addr),
        .load_data (a_load_data),
        .busy      (a_busy)
    );

    mips_dmem_ctrl #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .INIT_CLEAR(1'b0)) dut_b (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .bus       (b_if),
        .load_en   (b_load_en),
        .load_addr (b_load_addr),
        .load_data (b_load_data),
        .busy      (b_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk1);
    endtask

    task automatic drv(input bit sel, input logic v, input logic we, input logic [9:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
        if (!sel) begin
            a_if.req_valid = v; a_if.req_we = we; a_if.req_addr = addr;
            a_if.req_wdata = wd; a_if.req_be = be;
        end else begin
            b_if.req_valid = v; b_if.req_we = we; b_if.req_addr = addr;
            b_if.req_wdata = wd; b_if.req_be = be;
        end
    endtask

    task automatic chk_rsp(input string tag, input bit sel, input logic v, input logic e,
                           input logic [31:0] d);
        if (!sel) begin
            check({tag, ".valid"}, 64'(a_if.rsp_valid), 64'(v));
            check({tag, ".err"},   64'(a_if.rsp_err),   64'(e));
            check({tag, ".rdata"}, 64'(a_if.rsp_rdata), 64'(d));
        end else begin
            check({tag, ".valid"}, 64'(b_if.rsp_valid), 64'(v));
            check({tag, ".err"},   64'(b_if.rsp_err),   64'(e));
            check({tag, ".rdata"}, 64'(b_if.rsp_rdata), 64'(d));
        end
    endtask

    // Counts falling edges with busy high (bounded), and how many of those saw req_ready high.
    task automatic count_busy(output int n, output int rdy_hi);
        n = 0;
        rdy_hi = 0;
        for (int i = 0; i < 2000 && a_busy; i++) begin
            if (a_if.req_ready) rdy_hi++;
            n++;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_load_en = 1'b0; a_load_addr = '0; a_load_data = '0;
        b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        tick();
        tick();

        // Reset values
        check("rst.a_busy",      64'(a_busy),          64'd1);
        check("rst.a_ready",     64'(a_if.req_ready),  64'd0);
        check("rst.a_rsp_valid", 64'(a_if.rsp_valid),  64'd0);
        check("rst.a_rdata",     64'(a_if.rsp_rdata),  64'd0);
        check("rst.b_busy",      64'(b_busy),          64'd0);
        check("rst.b_ready",     64'(b_if.req_ready),  64'd1);

        // Clearing pass lasts exactly DEPTH cycles with req_ready low
        rst_n = 1'b1;
        count_busy(n_busy, n_rdy);
        check("init.busy_cycles", 64'(n_busy), 64'd1024);
        check("init.ready_high",  64'(n_rdy),  64'd0);
        check("init.ready_after", 64'(a_if.req_ready), 64'd1);

        drv(0, 1, 0, 10'd0, 0, 0);     tick(); chk_rsp("clr.load0",    0, 1, 0, 32'h0);
        drv(0, 1, 0, 10'd1023, 0, 0);  tick(); chk_rsp("clr.load1023", 0, 1, 0, 32'h0);
        drv(0, 0, 0, 0, 0, 0);         tick(); chk_rsp("clr.idle",     0, 0, 0, 32'h0);

        // Backdoor preload, load, store sum, load back
        a_load_en = 1'b1; a_load_addr = 10'd120; a_load_data = 32'd85;
        tick();
        a_load_en = 1'b0;
        drv(0, 1, 0, 10'd120, 0, 0);            tick(); chk_rsp("r1.load120",  0, 1, 0, 32'd85);
        drv(0, 1, 1, 10'd121, 32'd130, 4'hF);   tick(); chk_rsp("r1.store121", 0, 1, 0, 32'd0);
        drv(0, 1, 0, 10'd121, 0, 0);            tick(); chk_rsp("r1.load121",  0, 1, 0, 32'd130);
        drv(0, 0, 0, 0, 0, 0);                  tick(); chk_rsp("r1.idle",     0, 0, 0, 32'd0);

        // Byte-enable merge with back-to-back store/store/load, then an empty-mask store
        drv(0, 1, 1, 10'd5, 32'hAABBCCDD, 4'hF);  tick(); chk_rsp("be.st_full", 0, 1, 0, 32'h0);
        drv(0, 1, 1, 10'd5, 32'h11223344, 4'h5);  tick(); chk_rsp("be.st_0101", 0, 1, 0, 32'h0);
        drv(0, 1, 0, 10'd5, 0, 0);                tick(); chk_rsp("be.load5",   0, 1, 0, 32'hAA22CC44);
        drv(0, 1, 1, 10'd5, 32'hFFFFFFFF, 4'h0);  tick(); chk_rsp("be.st_none", 0, 1, 0, 32'h0);
        drv(0, 1, 0, 10'd5, 0, 0);                tick(); chk_rsp("be.reload5", 0, 1, 0, 32'hAA22CC44);
        drv(0, 0, 0, 0, 0, 0);                    tick(); chk_rsp("be.idle",    0, 0, 0, 32'h0);

        // Backdoor holds off a pending request; it is accepted once load_en drops
        a_load_en = 1'b1; a_load_addr = 10'd200; a_load_data = 32'h0000_1234;
        drv(0, 1, 0, 10'd200, 0, 0);
        #1 check("bd.ready_low", 64'(a_if.req_ready), 64'd0);
        tick(); chk_rsp("bd.stall1", 0, 0, 0, 32'h0);
        tick(); chk_rsp("bd.stall2", 0, 0, 0, 32'h0);
        a_load_en = 1'b0;
        #1 check("bd.ready_high", 64'(a_if.req_ready), 64'd1);
        tick(); chk_rsp("bd.load200", 0, 1, 0, 32'h0000_1234);
        drv(0, 0, 0, 0, 0, 0);
        tick(); chk_rsp("bd.idle", 0, 0, 0, 32'h0);

        // Range checks on the DEPTH=1000 instance
        b_load_en = 1'b1; b_load_addr = 10'd999;  b_load_data = 32'hDEAD_BEEF;
        tick();
        b_load_addr = 10'd1010; b_load_data = 32'h1;
        tick();
        b_load_en = 1'b0;
        drv(1, 1, 0, 10'd999, 0, 0);              tick(); chk_rsp("rng.load999",   1, 1, 0, 32'hDEAD_BEEF);
        drv(1, 1, 0, 10'd1000, 0, 0);             tick(); chk_rsp("rng.load1000",  1, 1, 1, 32'h0);
        drv(1, 1, 1, 10'd1023, 32'h5555, 4'hF);   tick(); chk_rsp("rng.store1023", 1, 1, 1, 32'h0);
        drv(1, 0, 0, 0, 0, 0);                    tick(); chk_rsp("rng.idle",      1, 0, 0, 32'h0);

        // Reset mid-clear, with a response in flight on the other instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (299) tick();
        drv(1, 1, 0, 10'd999, 0, 0);
        @(posedge clk1);
        #1;
        check("mid.b_rsp_valid", 64'(b_if.rsp_valid), 64'd1);
        check("mid.b_rsp_rdata", 64'(b_if.rsp_rdata), 64'hDEAD_BEEF);
        check("mid.a_busy",      64'(a_busy),         64'd1);
        rst_n = 1'b0;
        #1;
        check("mid.rst_b_valid", 64'(b_if.rsp_valid), 64'd0);
        check("mid.rst_b_rdata", 64'(b_if.rsp_rdata), 64'd0);
        check("mid.rst_a_busy",  64'(a_busy),         64'd1);
        check("mid.rst_a_ready", 64'(a_if.req_ready), 64'd0);
        drv(1, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        count_busy(n_busy, n_rdy);
        check("reinit.busy_cycles", 64'(n_busy), 64'd1024);
        check("reinit.ready_high",  64'(n_rdy),  64'd0);

        // Clearing wiped the old contents; the array without clearing kept its data
        drv(0, 1, 0, 10'd120, 0, 0);  tick(); chk_rsp("reinit.a_load120", 0, 1, 0, 32'h0);
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 10'd999, 0, 0);  tick(); chk_rsp("reinit.b_load999", 1, 1, 0, 32'hDEAD_BEEF);
        drv(1, 0, 0, 0, 0, 0);        tick(); chk_rsp("reinit.b_idle",    1, 0, 0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_dmem_ctrl.md
MIPS_DMEM_CTRL -- requirements
Module: mips_dmem_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10: word-address width.
REQ-003 Parameter DEPTH, default 1024: number of words, 1 <= DEPTH <= 2^ADDR_W; non-power-of-2 values allowed.
REQ-004 Parameter INIT_CLEAR, default 1: 1 = zero all words after reset; 0 = skip clearing.
REQ-005 clk1  input  1  sole clock, rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-009 req_we  input  1  1 = store, 0 = load.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  store data.
REQ-012 req_be  input  DATA_W/8  byte enables, bit i covers bits 8i+7..8i.
REQ-013 rsp_valid  output  1  one-cycle response pulse.
REQ-014 rsp_rdata  output  DATA_W  load data; 0 for stores and errors.
REQ-015 rsp_err  output  1  address out of range; valid with rsp_valid.
REQ-016 load_en  input  1  backdoor preload strobe (bench program/data loading).
REQ-017 load_addr  input  ADDR_W  backdoor word address.
REQ-018 load_data  input  DATA_W  backdoor full-word data.
REQ-019 busy  output  1  high while in INIT.

Function
REQ-020 FSM states: INIT, READY; INIT entered on reset release only when INIT_CLEAR=1, otherwise READY.
REQ-021 INIT: clear counter steps 0..DEPTH-1, writing 0 to one word per cycle; the cycle that writes DEPTH-1 transitions to READY; busy=1 and req_ready=0 throughout.
REQ-022 req_ready SHALL equal (state==READY) AND NOT load_en (combinational).
REQ-023 Accept = req_valid AND req_ready; accepted store writes only bytes with req_be set; req_be=0 leaves memory unchanged but is still acknowledged.
REQ-024 Every accepted request produces rsp_valid=1 exactly one cycle later; no response backpressure; back-to-back requests yield back-to-back responses.
REQ-025 Load latency: rsp_rdata = word contents as of the acceptance edge, including any store accepted on the immediately preceding cycle (read-after-write returns new data).
REQ-026 req_addr >= DEPTH: no memory access, response carries rsp_err=1 and rsp_rdata=0.
REQ-027 load_en writes load_data to load_addr (full word) in any state; load_addr >= DEPTH ignored silently; in INIT, a backdoor write to the word being cleared that cycle wins.
REQ-028 load_en does not generate rsp_valid.
REQ-029 Unaccepted req_valid with req_ready=0 has no effect; requester holds the request.

Reset
REQ-030 rst_n low asynchronously forces: state=INIT (INIT_CLEAR=1) or READY (INIT_CLEAR=0), clear counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=INIT_CLEAR, in-flight response discarded.
REQ-031 Memory array is not reset by rst_n; only INIT clears it; reset during INIT restarts clearing from word 0.

Verification
REQ-032 INIT_CLEAR=1, DEPTH=1024: release reset -> busy=1 for exactly 1024 cycles, req_ready=0 throughout, then any load returns 0.
REQ-033 Backdoor Mem[120]=85; store word 1(R1)-style: load 120 -> 85; store 130 (85+45) to 121 with be=4'hF; load 121 -> 130, rsp_err=0.
REQ-034 Store 0xAABBCCDD to addr 5, then store 0x11223344 with be=4'b0101 next cycle, then load 5 back-to-back -> 0xAA22CC44.
REQ-035 DEPTH=1000: load addr 1000 -> rsp_valid=1, rsp_err=1, rsp_rdata=0; store to 1023 -> no change, rsp_err=1.
REQ-036 load_en held high with req_valid high -> req_ready=0, no rsp_valid; release load_en -> request accepted next cycle, response one cycle later.
REQ-037 Assert rst_n low mid-INIT at counter=300 -> outputs reset immediately; on release busy lasts a full 1024 cycles.
